// File: rtl/bus_fairness_checker.sv
`default_nettype none
// ============================================================================
// Module   : bus_fairness_checker
// Brief    : Wishbone wait-state fairness and RVFI trap-nesting checker.
//            Tracks stall cycles per transaction and trap nesting depth, and
//            raises sticky violation flags (timeout, early ack, stray ack,
//            nest overflow) that stay set until clr_err.
//            Optional macro FAIRNESS_ASSUME_EN: every violation condition also
//            drives an immediate assume(!cond) for formal environments.
// Revision : 1.0 - initial release
// ============================================================================
module bus_fairness_checker #(
  parameter int MAX_WAIT   = 4,
  parameter int MIN_WAIT   = 1,
  parameter int NEST_DEPTH = 1,
  parameter int CNT_W      = $clog2(MAX_WAIT + 1),
  parameter int LVL_W      = $clog2(NEST_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus__cyc,
  input  logic             bus__stb,
  input  logic             bus__ack,
  input  logic             rvfi__valid,
  input  logic             rvfi__trap,
  input  logic             insn_mret,
  input  logic             clr_err,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [LVL_W-1:0] nest_lvl,
  output logic             err_timeout,
  output logic             err_early_ack,
  output logic             err_stray_ack,
  output logic             err_nest,
  output logic             err_any
);

  localparam logic [CNT_W-1:0] c_MAX_WAIT_M1 = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] c_MIN_WAIT    = CNT_W'(MIN_WAIT);
  localparam logic [LVL_W-1:0] c_NEST_DEPTH  = LVL_W'(NEST_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_STALLED = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [LVL_W-1:0] nest_lvl_q, nest_lvl_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_early_q, err_early_d;
  logic             err_stray_q, err_stray_d;
  logic             err_nest_q, err_nest_d;

  // Violation conditions, all evaluated on the current cycle's inputs.
  logic timeout_c, early_c, stray_c, nest_c;
  logic trap_in, mret_in;

  assign trap_in   = rvfi__valid && rvfi__trap && !insn_mret;
  assign mret_in   = rvfi__valid && insn_mret;

  // A stall while already saturated is the (MAX_WAIT+1)th consecutive stall.
  assign timeout_c = bus__cyc && !bus__ack && (state_q == S_STALLED);
  assign early_c   = bus__cyc && bus__ack && (wait_cnt_q < c_MIN_WAIT);
  assign stray_c   = bus__ack && (!bus__cyc || !bus__stb);
  assign nest_c    = trap_in && (nest_lvl_q == c_NEST_DEPTH);

  // Bus FSM and stall counter: counter restarts on every ack or idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else if (!bus__cyc || bus__ack) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        S_STALLED: begin
          // Saturated: hold the count, never wrap.
          state_q    <= S_STALLED;
          wait_cnt_q <= wait_cnt_q;
        end
        default: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          state_q    <= (wait_cnt_q == c_MAX_WAIT_M1) ? S_STALLED : S_WAIT;
        end
      endcase
    end
  end

  // Next nesting level: traps push, MRET pops (MRET wins over a trap).
  always_comb begin
    nest_lvl_d = nest_lvl_q;
    if (mret_in) begin
      if (nest_lvl_q != '0) begin
        nest_lvl_d = nest_lvl_q - 1'b1;
      end
    end else if (trap_in && !nest_c) begin
      nest_lvl_d = nest_lvl_q + 1'b1;
    end
  end

  // Sticky flags: a new violation overrides a same-cycle clear.
  always_comb begin
    err_timeout_d = (err_timeout_q && !clr_err) || timeout_c;
    err_early_d   = (err_early_q   && !clr_err) || early_c;
    err_stray_d   = (err_stray_q   && !clr_err) || stray_c;
    err_nest_d    = (err_nest_q    && !clr_err) || nest_c;
  end

  // Register nesting level and error flags; optionally constrain the solver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nest_lvl_q    <= '0;
      err_timeout_q <= 1'b0;
      err_early_q   <= 1'b0;
      err_stray_q   <= 1'b0;
      err_nest_q    <= 1'b0;
    end else begin
      nest_lvl_q    <= nest_lvl_d;
      err_timeout_q <= err_timeout_d;
      err_early_q   <= err_early_d;
      err_stray_q   <= err_stray_d;
      err_nest_q    <= err_nest_d;
`ifdef FAIRNESS_ASSUME_EN
      a_no_timeout:   assume (!timeout_c);
      a_no_early_ack: assume (!early_c);
      a_no_stray_ack: assume (!stray_c);
      a_no_nest_ovf:  assume (!nest_c);
`else
`endif
    end
  end

  assign wait_cnt      = wait_cnt_q;
  assign nest_lvl      = nest_lvl_q;
  assign err_timeout   = err_timeout_q;
  assign err_early_ack = err_early_q;
  assign err_stray_ack = err_stray_q;
  assign err_nest      = err_nest_q;
  assign err_any       = err_timeout_q | err_early_q | err_stray_q | err_nest_q;

endmodule
`default_nettype wire
